// File: rtl/step_cmd_pkg.sv
// Shared types and default widths for the step command front-end.
package step_cmd_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DIV_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/step_timer.sv
// Reloadable down-counter: tick_o marks the zero cycle, and the count
// reloads from the value captured at load while running.
module step_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         run_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] reload_q, reload_d;

    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (load_i) begin
            cnt_d    = load_val_i;
            reload_d = load_val_i;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? reload_q : cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/step_cmd_gen.sv
// Move-command front-end for the stepper phase core: accepts a command and
// emits evenly spaced single-cycle enable strobes with a stable direction.
module step_cmd_gen
    import step_cmd_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             dir,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left,
    output state_e           state_dbg
);

    // Handshake: a command transfers on a rising clk edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE, no queuing.

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic             accept;
    logic             tick;
    logic             step;
    logic [DIV_W-1:0] reload_val;

    assign accept     = (state_q == ST_IDLE) && cmd_valid;
    // A zero period behaves as one: a strobe every cycle.
    assign reload_val = (cmd_period == '0) ? '0 : cmd_period - DIV_W'(1);

    step_timer #(
        .W (DIV_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (accept),
        .load_val_i (reload_val),
        .run_i      (state_q == ST_RUN),
        .tick_o     (tick)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        aborted_d = aborted_q;
        left_d    = left_q;
        step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_d     = cmd_dir;
                    left_d    = cmd_steps;
                    aborted_d = 1'b0;
                    state_d   = (cmd_steps != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // Abort wins over a strobe due in the same cycle.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (tick && left_q != '0) begin
                    step   = 1'b1;
                    left_d = left_q - CNT_W'(1);
                    if (left_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            aborted_q <= 1'b0;
            left_q    <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            aborted_q <= aborted_d;
            left_q    <= left_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign enable     = step;
    assign dir        = dir_q;
    assign aborted    = aborted_q;
    assign steps_left = left_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_step_cmd_gen.sv
// Self-checking bench for step_cmd_gen against a cycle-schedule model.
module tb_step_cmd_gen;
    import step_cmd_pkg::*;

    localparam int CW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [CW-1:0] cmd_steps;
    logic [DW-1:0] cmd_period;
    logic          abort;
    logic          dir;
    logic          enable;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] steps_left;
    state_e        state_dbg;

    int checks = 0;
    int errors = 0;

    step_cmd_gen #(
        .CNT_W (CW),
        .DIV_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .dir        (dir),
        .enable     (enable),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_left (steps_left),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One move, modelled as a schedule: relative cycle k=1 is the first cycle
    // after the accepting edge; strobes fall on multiples of P while running.
    task automatic move(input bit d, input int n, input int per, input int a, input bit hold);
        int  p;
        int  run_end;
        int  dk;
        int  exp_left;
        bit  ab;
        bit  in_run;
        p       = (per == 0) ? 1 : per;
        ab      = (n > 0) && (a >= 1) && (a <= n * p);
        run_end = ab ? a : n * p;
        dk      = run_end + 1;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = CW'(n);
        cmd_period = DW'(per);
        abort      = 1'b0;
        #1;
        chk("ready_idle", 32'(cmd_ready), 32'(1));
        chk("busy_idle", 32'(busy), 32'(0));
        chk("enable_idle", 32'(enable), 32'(0));
        for (int k = 1; k <= dk; k++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            cmd_dir    = ~d;
            cmd_steps  = CW'($urandom_range(1, 50));
            cmd_period = DW'($urandom_range(0, 7));
            abort      = (k == a);
            #1;
            in_run   = (k <= run_end);
            exp_left = in_run ? n - (k - 1) / p : (ab ? n - (a - 1) / p : 0);
            chk("enable", 32'(enable), 32'(in_run && (k % p == 0) && (k != a)));
            chk("busy", 32'(busy), 32'(in_run));
            chk("dir", 32'(dir), 32'(d));
            chk("ready_busy", 32'(cmd_ready), 32'(0));
            chk("done", 32'(done), 32'(k == dk));
            chk("steps_left", 32'(steps_left), 32'(exp_left));
            if (k == dk) chk("aborted", 32'(aborted), 32'(ab));
        end
        abort = 1'b0;
    endtask

    initial begin
        int n;
        int per;
        int p;
        int a;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;
        #12;
        chk("rst_ready", 32'(cmd_ready), 32'(1));
        chk("rst_enable", 32'(enable), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_aborted", 32'(aborted), 32'(0));
        chk("rst_dir", 32'(dir), 32'(0));
        chk("rst_steps_left", 32'(steps_left), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        move(1'b1, 3, 4, 0, 1'b0);
        move(1'b0, 5, 0, 0, 1'b0);
        move(1'b1, 0, 7, 0, 1'b0);
        move(1'b0, 10, 2, 6, 1'b0);

        // Reset in the middle of a strobe cycle of a long move.
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = CW'(100);
        cmd_period = DW'(4);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_enable", 32'(enable), 32'(1));
        chk("mid_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        chk("arst_enable", 32'(enable), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_steps_left", 32'(steps_left), 32'(0));
        chk("arst_dir", 32'(dir), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_ready", 32'(cmd_ready), 32'(1));

        // cmd_valid held high with alternating direction.
        for (int i = 0; i < 6; i++) begin
            move(i[0], int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 0, 1'b1);
        end
        @(negedge clk);
        cmd_valid = 1'b0;

        repeat (30) begin
            n   = int'($urandom_range(0, 6));
            per = int'($urandom_range(0, 5));
            p   = (per == 0) ? 1 : per;
            a   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n * p + 1)) : 0;
            move(1'($urandom_range(0, 1)), n, per, a, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
